// File: rtl/hps_noc_port_arbiter.sv
// Shares one NoC local port between two HPS CPU mailboxes: round-robin TX
// serialization with toggle handshakes, and RX steering by a flit select bit.
module hps_noc_port_arbiter #(
    parameter int NUM_WORDS = 8,
    parameter int SEL_BIT   = 224,
    parameter int CNT_W     = 8,
    localparam int FW       = 32 * NUM_WORDS
) (
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    input  logic [FW-1:0] cpu0_tx_data,
    input  logic [FW-1:0] cpu1_tx_data,
    output logic [FW-1:0] cpu0_rx_data,
    output logic [FW-1:0] cpu1_rx_data,
    input  logic [31:0]   noc_ctrl_0,
    input  logic [31:0]   noc_ctrl_1,
    output logic [31:0]   noc_status_0,
    output logic [31:0]   noc_status_1,
    output logic [FW-1:0] noc_tx_data,
    output logic          noc_tx_valid,
    input  logic          noc_tx_ready,
    input  logic [FW-1:0] noc_rx_data,
    input  logic          noc_rx_valid,
    output logic          noc_rx_ready
);

    typedef enum logic [0:0] {
        T_IDLE = 1'b0,
        T_SEND = 1'b1
    } tx_state_e;

    tx_state_e                  state_q, state_d;
    logic                       grant_q, grant_d;
    logic                       rr_q, rr_d;
    logic [1:0]                 seen_q, seen_d;
    logic [1:0]                 done_q, done_d;
    logic [FW-1:0]              tx_data_q, tx_data_d;
    logic [1:0][CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
    logic [1:0]                 rx_vld_q, rx_vld_d;
    logic [1:0][FW-1:0]         rx_data_q, rx_data_d;
    logic [1:0][CNT_W-1:0]      rx_cnt_q, rx_cnt_d;

    logic [1:0] tx_req_s;
    logic [1:0] rx_ack_s;
    logic [1:0] pend_s;
    logic [1:0] rx_full_s;
    logic [1:0] busy_s;
    logic       gsel_s;
    logic       rx_sel_s;
    logic       rx_accept_s;
    logic       unused_ctrl_s;

    function automatic logic [31:0] pack_status(
        input logic             done,
        input logic             vld,
        input logic             busy,
        input logic             full,
        input logic [CNT_W-1:0] txc,
        input logic [CNT_W-1:0] rxc
    );
        logic [31:0] s;
        s        = 32'd0;
        s[0]     = done;
        s[1]     = vld;
        s[2]     = busy;
        s[3]     = full;
        s[15:8]  = 8'(txc);
        s[23:16] = 8'(rxc);
        return s;
    endfunction

    assign unused_ctrl_s = ^{noc_ctrl_0[31:2], noc_ctrl_1[31:2]};

    // Request/ack decode; the pending view stays live while a flit is in flight.
    always_comb begin
        tx_req_s  = {noc_ctrl_1[0], noc_ctrl_0[0]};
        rx_ack_s  = {noc_ctrl_1[1], noc_ctrl_0[1]};
        pend_s    = tx_req_s ^ seen_q;
        rx_full_s = rx_vld_q ^ rx_ack_s;
        if (pend_s == 2'b11) begin
            gsel_s = rr_q;
        end else begin
            gsel_s = pend_s[1];
        end
        busy_s[0] = pend_s[0] | ((state_q == T_SEND) && (grant_q == 1'b0));
        busy_s[1] = pend_s[1] | ((state_q == T_SEND) && (grant_q == 1'b1));
    end

    // TX arbitration and serialization FSM.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        seen_d    = seen_q;
        done_d    = done_q;
        tx_data_d = tx_data_q;
        tx_cnt_d  = tx_cnt_q;
        case (state_q)
            T_IDLE: begin
                if (|pend_s) begin
                    grant_d         = gsel_s;
                    tx_data_d       = gsel_s ? cpu1_tx_data : cpu0_tx_data;
                    seen_d[gsel_s]  = tx_req_s[gsel_s];
                    rr_d            = ~gsel_s;
                    state_d         = T_SEND;
                end else begin
                    state_d = T_IDLE;
                end
            end
            T_SEND: begin
                if (noc_tx_ready) begin
                    done_d[grant_q]   = ~done_q[grant_q];
                    tx_cnt_d[grant_q] = tx_cnt_q[grant_q] + CNT_W'(1);
                    state_d           = T_IDLE;
                end else begin
                    state_d = T_SEND;
                end
            end
            default: begin
                state_d = T_IDLE;
            end
        endcase
    end

    // RX steering: ready is combinational so a same-cycle ack frees the slot.
    always_comb begin
        rx_sel_s    = noc_rx_data[SEL_BIT];
        rx_accept_s = noc_rx_valid & ~rx_full_s[rx_sel_s];
        rx_data_d   = rx_data_q;
        rx_vld_d    = rx_vld_q;
        rx_cnt_d    = rx_cnt_q;
        if (rx_accept_s) begin
            rx_data_d[rx_sel_s] = noc_rx_data;
            rx_vld_d[rx_sel_s]  = ~rx_vld_q[rx_sel_s];
            rx_cnt_d[rx_sel_s]  = rx_cnt_q[rx_sel_s] + CNT_W'(1);
        end else begin
            rx_vld_d = rx_vld_q;
        end
    end

    // State registers for both paths.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q   <= T_IDLE;
            grant_q   <= 1'b0;
            rr_q      <= 1'b0;
            seen_q    <= 2'b00;
            done_q    <= 2'b00;
            tx_data_q <= '0;
            tx_cnt_q  <= '0;
            rx_vld_q  <= 2'b00;
            rx_data_q <= '0;
            rx_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            seen_q    <= seen_d;
            done_q    <= done_d;
            tx_data_q <= tx_data_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_vld_q  <= rx_vld_d;
            rx_data_q <= rx_data_d;
            rx_cnt_q  <= rx_cnt_d;
        end
    end

    assign noc_tx_valid = (state_q == T_SEND);
    assign noc_tx_data  = tx_data_q;
    assign noc_rx_ready = ~rx_full_s[noc_rx_data[SEL_BIT]];
    assign cpu0_rx_data = rx_data_q[0];
    assign cpu1_rx_data = rx_data_q[1];
    assign noc_status_0 = pack_status(done_q[0], rx_vld_q[0], busy_s[0], rx_full_s[0],
                                      tx_cnt_q[0], rx_cnt_q[0]);
    assign noc_status_1 = pack_status(done_q[1], rx_vld_q[1], busy_s[1], rx_full_s[1],
                                      tx_cnt_q[1], rx_cnt_q[1]);

endmodule
